// File: rtl/audio_score_pkg.sv
// audio_score_pkg
//   Shared definitions for the pitch scoring pipeline: score width and
//   range, bin-error saturation limit, and the scorer state encoding.
//   Used by pitch_scorer, score_map, the downstream tally stage and
//   later score consumers.
package audio_score_pkg;

   localparam int SCORE_W   = 4;
   localparam int SCORE_MAX = 15;
   localparam int ERR_W     = 8;
   localparam int MAX_ERR   = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SCORE = 2'd2,
      EMIT  = 2'd3
   } state_t;

   // Saturate an absolute bin distance to the 8-bit error range.
   function automatic logic [ERR_W-1:0] clamp_err(input logic [31:0] diff);
      if (diff > 32'(MAX_ERR)) begin
         clamp_err = ERR_W'(MAX_ERR);
      end else begin
         clamp_err = diff[ERR_W-1:0];
      end
   endfunction

endpackage

// File: rtl/pitch_scorer_score_map.sv
// score_map
//   Combinational map from a mean bin error to a 4-bit pitch score.
//   Errors up to TOL score SCORE_MAX; each further 2^STEP_SHIFT bins of
//   error costs one point, floored at 0.
// Ports:
//   avg    in   ERR_W     mean absolute bin error of a frame
//   score  out  SCORE_W   resulting score
module score_map
   import audio_score_pkg::*;
#(
   parameter int TOL        = 2,
   parameter int STEP_SHIFT = 1
) (
   input  logic [ERR_W-1:0]   avg,
   output logic [SCORE_W-1:0] score
);

   logic [ERR_W-1:0] dev_s;
   logic [ERR_W-1:0] steps_s;

   // Deviation beyond tolerance, quantised into score steps.
   always_comb begin
      dev_s   = {ERR_W{1'b0}};
      steps_s = {ERR_W{1'b0}};
      score   = {SCORE_W{1'b0}};
      if (avg > ERR_W'(TOL)) begin
         dev_s = avg - ERR_W'(TOL);
      end else begin
         dev_s = {ERR_W{1'b0}};
      end
      steps_s = dev_s >> STEP_SHIFT;
      if (steps_s >= ERR_W'(SCORE_MAX)) begin
         score = {SCORE_W{1'b0}};
      end else begin
         score = SCORE_W'(SCORE_MAX) - steps_s[SCORE_W-1:0];
      end
   end

endmodule

// File: rtl/pitch_scorer.sv
// pitch_scorer
//   Scores how closely the FFT peak tracks a target note. Collects
//   2^LOG2_FRAME peak reports, averages the saturated absolute bin error
//   and maps it to a 4-bit score, emitted with a one-cycle score_ready
//   pulse two cycles after the last report of the frame.
//   Optional macro PITCH_SCORER_SILENCE_GATE_EN: low-magnitude reports
//   count as maximum error, and a mostly-silent frame pulses silent
//   instead of score_ready while score is held.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   enable       in   scoring enabled; low aborts any frame
//   target_bin   in   target note bin, sampled at frame start
//   peak_valid   in   peak report strobe
//   peak_bin     in   detected peak bin
//   peak_mag     in   detected peak magnitude
//   score        out  last frame score, held between frames
//   score_ready  out  one-cycle pulse, new score valid
//   silent       out  one-cycle pulse, frame judged silent (0 without macro)
//   busy         out  high in ACCUM/SCORE/EMIT
module pitch_scorer
   import audio_score_pkg::*;
#(
   parameter int BIN_W      = 10,
   parameter int MAG_W      = 16,
   parameter int LOG2_FRAME = 3,
   parameter int TOL        = 2,
   parameter int STEP_SHIFT = 1,
   parameter int MAG_THRESH = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [BIN_W-1:0]     target_bin,
   input  logic                 peak_valid,
   input  logic [BIN_W-1:0]     peak_bin,
   input  logic [MAG_W-1:0]     peak_mag,
   output logic [SCORE_W-1:0]   score,
   output logic                 score_ready,
   output logic                 silent,
   output logic                 busy
);

   localparam int SUM_W   = ERR_W + LOG2_FRAME;
   localparam int CNT_W   = LOG2_FRAME + 1;
   localparam int FRAME_N = 1 << LOG2_FRAME;

   state_t               state_r;
   state_t               state_next_s;
   logic [BIN_W-1:0]     target_r;
   logic [CNT_W-1:0]     count_r;
   logic [SUM_W-1:0]     sum_r;
   logic [SCORE_W-1:0]   score_next_r;
   logic [SCORE_W-1:0]   score_r;
   logic                 score_ready_r;
   logic                 busy_r;
   logic [BIN_W-1:0]     diff_s;
   logic [ERR_W-1:0]     err_s;
   logic [ERR_W-1:0]     add_err_s;
   logic [ERR_W-1:0]     avg_s;
   logic [SCORE_W-1:0]   map_score_s;
   logic                 last_s;
   logic                 unused_sum_s;

   // Current report's error contribution and end-of-frame detection.
   always_comb begin
      diff_s    = {BIN_W{1'b0}};
      add_err_s = {ERR_W{1'b0}};
      if (peak_bin >= target_r) begin
         diff_s = peak_bin - target_r;
      end else begin
         diff_s = target_r - peak_bin;
      end
      err_s = clamp_err(32'(diff_s));
`ifdef PITCH_SCORER_SILENCE_GATE_EN
      if (peak_mag < MAG_W'(MAG_THRESH)) begin
         add_err_s = ERR_W'(MAX_ERR);
      end else begin
         add_err_s = err_s;
      end
`else
      add_err_s = err_s;
`endif
      last_s = (state_r == ACCUM) && peak_valid &&
               (count_r == CNT_W'(FRAME_N - 1));
   end

   // Mean error is the sum with the frame-size bits dropped.
   assign avg_s        = sum_r[SUM_W-1:LOG2_FRAME];
   assign unused_sum_s = ^sum_r[LOG2_FRAME-1:0];

   score_map #(
      .TOL        (TOL),
      .STEP_SHIFT (STEP_SHIFT)
   ) u_score_map (
      .avg   (avg_s),
      .score (map_score_s)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; dropping enable wins over everything.
   always_comb begin
      state_next_s = state_r;
      if (!enable) begin
         state_next_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_next_s = ACCUM;
            ACCUM:   begin
               if (last_s) begin
                  state_next_s = SCORE;
               end else begin
                  state_next_s = ACCUM;
               end
            end
            SCORE:   state_next_s = EMIT;
            EMIT:    state_next_s = ACCUM;
            default: state_next_s = IDLE;
         endcase
      end
   end

`ifdef PITCH_SCORER_SILENCE_GATE_EN
   logic [CNT_W-1:0] silent_cnt_r;
   logic             silent_r;

   // Silent-report counter and silent pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         silent_cnt_r <= {CNT_W{1'b0}};
         silent_r     <= 1'b0;
      end else begin
         silent_r <= 1'b0;
         if (!enable) begin
            silent_cnt_r <= {CNT_W{1'b0}};
         end else if (state_r == IDLE) begin
            silent_cnt_r <= {CNT_W{1'b0}};
         end else if (state_r == ACCUM) begin
            if (peak_valid && (peak_mag < MAG_W'(MAG_THRESH))) begin
               silent_cnt_r <= silent_cnt_r + CNT_W'(1);
            end else begin
               silent_cnt_r <= silent_cnt_r;
            end
         end else if (state_r == EMIT) begin
            silent_r     <= (silent_cnt_r > CNT_W'(FRAME_N / 2));
            silent_cnt_r <= {CNT_W{1'b0}};
         end else begin
            silent_cnt_r <= silent_cnt_r;
         end
      end
   end

   logic frame_silent_s;
   assign frame_silent_s = (silent_cnt_r > CNT_W'(FRAME_N / 2));
   assign silent         = silent_r;
`else
   logic frame_silent_s;
   logic unused_mag_s;
   assign frame_silent_s = 1'b0;
   assign unused_mag_s   = ^{peak_mag, MAG_W'(MAG_THRESH)};
   assign silent         = 1'b0;
`endif

   // Frame accumulation, score registration and the score_ready pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         target_r      <= {BIN_W{1'b0}};
         count_r       <= {CNT_W{1'b0}};
         sum_r         <= {SUM_W{1'b0}};
         score_next_r  <= {SCORE_W{1'b0}};
         score_r       <= {SCORE_W{1'b0}};
         score_ready_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         score_ready_r <= 1'b0;
         busy_r        <= (state_next_s != IDLE);
         if (!enable) begin
            count_r <= {CNT_W{1'b0}};
            sum_r   <= {SUM_W{1'b0}};
         end else begin
            case (state_r)
               IDLE: begin
                  target_r <= target_bin;
                  count_r  <= {CNT_W{1'b0}};
                  sum_r    <= {SUM_W{1'b0}};
               end
               ACCUM: begin
                  if (peak_valid) begin
                     sum_r   <= sum_r + SUM_W'(add_err_s);
                     count_r <= count_r + CNT_W'(1);
                  end else begin
                     sum_r   <= sum_r;
                     count_r <= count_r;
                  end
               end
               SCORE: begin
                  score_next_r <= map_score_s;
               end
               EMIT: begin
                  // Fresh frame starts on the same edge as the emit.
                  target_r <= target_bin;
                  count_r  <= {CNT_W{1'b0}};
                  sum_r    <= {SUM_W{1'b0}};
                  if (!frame_silent_s) begin
                     score_r       <= score_next_r;
                     score_ready_r <= 1'b1;
                  end else begin
                     score_r <= score_r;
                  end
               end
               default: begin
                  count_r <= {CNT_W{1'b0}};
                  sum_r   <= {SUM_W{1'b0}};
               end
            endcase
         end
      end
   end

   assign score       = score_r;
   assign score_ready = score_ready_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_pitch_scorer.sv
// tb_pitch_scorer
//   Scoreboard bench for pitch_scorer: each completed frame pushes its
//   expected pulse (kind, score, cycle) computed from plain arithmetic;
//   a monitor pops and compares whenever score_ready or silent is seen.
module tb_pitch_scorer;

   localparam int BIN_W      = 10;
   localparam int MAG_W      = 16;
   localparam int FRAME_N    = 8;
   localparam int TOL        = 2;
   localparam int STEP_SHIFT = 1;
   localparam int MAG_THRESH = 256;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             enable = 1'b0;
   logic [BIN_W-1:0] target_bin = '0;
   logic             peak_valid = 1'b0;
   logic [BIN_W-1:0] peak_bin = '0;
   logic [MAG_W-1:0] peak_mag = '0;
   logic [3:0]       score;
   logic             score_ready;
   logic             silent;
   logic             busy;

   pitch_scorer dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .target_bin  (target_bin),
      .peak_valid  (peak_valid),
      .peak_bin    (peak_bin),
      .peak_mag    (peak_mag),
      .score       (score),
      .score_ready (score_ready),
      .silent      (silent),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;   // 0 = score_ready, 1 = silent
      int score;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   held_score = 0;
   int   bins_a[FRAME_N];
   int   mags_a[FRAME_N];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: mean error -> score.
   function automatic int ref_score(input int sum);
      int avg, dev, steps;
      avg   = sum / FRAME_N;
      dev   = (avg > TOL) ? avg - TOL : 0;
      steps = dev / (1 << STEP_SHIFT);
      return (steps >= 15) ? 0 : 15 - steps;
   endfunction

   // Drive n reports from bins_a/mags_a with random gaps; target_bin is
   // scrambled meanwhile since mid-frame changes must be ignored.
   task automatic send_reports(input int n);
      for (int i = 0; i < n; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            peak_valid = 1'b0;
            target_bin = BIN_W'($urandom_range(0, 1023));
            tick();
         end
         peak_valid = 1'b1;
         peak_bin   = BIN_W'(bins_a[i]);
         peak_mag   = MAG_W'(mags_a[i]);
         target_bin = BIN_W'($urandom_range(0, 1023));
         tick();
      end
      peak_valid = 1'b0;
   endtask

   // Full frame against latched target tgt; next_tgt is presented for the
   // frame that starts on the emit edge.
   task automatic send_frame(input int tgt, input int next_tgt);
      int   sum, sil, e;
      exp_t x;
      sum = 0;
      sil = 0;
      for (int i = 0; i < FRAME_N; i++) begin
         e = (bins_a[i] > tgt) ? bins_a[i] - tgt : tgt - bins_a[i];
         if (e > 255) e = 255;
`ifdef PITCH_SCORER_SILENCE_GATE_EN
         if (mags_a[i] < MAG_THRESH) begin
            e = 255;
            sil++;
         end
`endif
         sum += e;
      end
      send_reports(FRAME_N);
      x.cyc = cyc + 2;
      if (sil > FRAME_N / 2) begin
         x.kind  = 1;
         x.score = held_score;
      end else begin
         x.kind  = 0;
         x.score = ref_score(sum);
         held_score = x.score;
      end
      exp_q.push_back(x);
      // Reports arriving during SCORE and EMIT must be discarded.
      peak_valid = 1'b1;
      peak_bin   = BIN_W'($urandom_range(0, 1023));
      peak_mag   = 16'd0;
      tick();
      target_bin = BIN_W'(next_tgt);
      peak_bin   = BIN_W'($urandom_range(0, 1023));
      tick();
      peak_valid = 1'b0;
   endtask

   task automatic fill(input int bin, input int mag);
      for (int i = 0; i < FRAME_N; i++) begin
         bins_a[i] = bin;
         mags_a[i] = mag;
      end
   endtask

   task automatic start_frame(input int tgt);
      target_bin = BIN_W'(tgt);
      enable     = 1'b1;
      tick();
   endtask

   // Monitor: pop and compare on every output pulse.
   always @(negedge clk) begin
      if (score_ready === 1'b1 || silent === 1'b1) begin
         check("pulse_exclusive", 32'(score_ready & silent), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(score), 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check("pulse_kind", 32'(silent), 32'(mon_e.kind));
            check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
            check("pulse_score", 32'(score), 32'(mon_e.score));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cur_tgt, nxt, off, b;

      // Reset state.
      reset = 1'b0;
      repeat (3) tick();
      check("rst_score", 32'(score), 32'd0);
      check("rst_ready", 32'(score_ready), 32'd0);
      check("rst_silent", 32'(silent), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      tick();
      check("idle_busy", 32'(busy), 32'd0);

      // On pitch, small error, clamped error, then recovery.
      start_frame(100);
      check("busy_accum", 32'(busy), 32'd1);
      fill(100, 1000);  send_frame(100, 100);
      fill(106, 1000);  send_frame(100, 100);
      fill(400, 1000);  send_frame(100, 100);
      fill(100, 1000);  send_frame(100, 100);
      enable = 1'b0;
      tick();
      check("busy_after_disable", 32'(busy), 32'd0);
      check("score_held", 32'(score), 32'(held_score));

      // Aborted frame, then a fresh frame at error 3.
      start_frame(100);
      fill(103, 1000);
      send_reports(4);
      enable = 1'b0;
      repeat (2) tick();
      start_frame(100);
      send_frame(100, 100);

      // Disable on the same cycle as the last report: no pulse.
      fill(300, 1000);
      send_reports(FRAME_N - 1);
      peak_valid = 1'b1;
      enable     = 1'b0;
      tick();
      peak_valid = 1'b0;
      repeat (3) tick();
      check("busy_priority_abort", 32'(busy), 32'd0);

      // Five of eight low-magnitude reports.
      start_frame(100);
      fill(100, 1000);
      for (int i = 0; i < 5; i++) mags_a[i] = 100;
      send_frame(100, 100);
      enable = 1'b0;
      tick();
      check("score_after_silence_frame", 32'(score), 32'(held_score));

      // Async reset mid-frame.
      start_frame(100);
      fill(100, 1000);
      send_reports(5);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_score", 32'(score), 32'd0);
      check("midrst_ready", 32'(score_ready), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_silent", 32'(silent), 32'd0);
      held_score = 0;
      tick();
      reset = 1'b1;
      start_frame(100);
      send_frame(100, 100);

      // Randomised frames back to back.
      cur_tgt = 100;
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < FRAME_N; i++) begin
            case ($urandom_range(0, 2))
               0:       off = int'($urandom_range(0, 16)) - 8;
               1:       off = int'($urandom_range(0, 80)) - 40;
               default: off = int'($urandom_range(0, 1023)) - cur_tgt;
            endcase
            b = cur_tgt + off;
            if (b < 0) b = 0;
            if (b > 1023) b = 1023;
            bins_a[i] = b;
            mags_a[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255))
                                                     : int'($urandom_range(256, 65535));
         end
         nxt = int'($urandom_range(0, 1023));
         send_frame(cur_tgt, nxt);
         cur_tgt = nxt;
      end

      enable = 1'b0;
      repeat (5) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("final_score_held", 32'(score), 32'(held_score));
      check("final_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pitch_scorer.md
Name: pitch_scorer

Overview:
- Scores how closely the detected spectral peak tracks a target note, one score per analysis frame.
- Collects 2^LOG2_FRAME peak reports from the FFT peak-picker and forms the mean absolute bin error.
- Maps that error to a 4-bit score (15 = on pitch, 0 = far off).
- Emits score with a 1-cycle score_ready pulse directly into the downstream score-averaging tally stage.

Parameters:
- BIN_W, 10: width of FFT bin indices.
- MAG_W, 16: width of peak magnitude.
- LOG2_FRAME, 3: log2 of peak reports per frame (default 8).
- TOL, 2: mean error in bins at or below which the score is 15.
- STEP_SHIFT, 1: each 2^STEP_SHIFT bins of error beyond TOL costs one score point.
- MAG_THRESH, 256: magnitude below which a report is silent (only used with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; clears all state.
- enable  in  1  scoring enabled; low aborts any frame.
- target_bin  in  BIN_W  target note bin; sampled at frame start.
- peak_valid  in  1  one-cycle strobe, peak report present.
- peak_bin  in  BIN_W  detected peak bin.
- peak_mag  in  MAG_W  detected peak magnitude.
- score  out  4  last frame score; held between frames.
- score_ready  out  1  one-cycle pulse, new score valid.
- silent  out  1  one-cycle pulse, frame judged silent (optional feature only; tied 0 otherwise).
- busy  out  1  high in ACCUM/SCORE/EMIT.

Behaviour:
- Reset values: score=0, score_ready=0, silent=0, busy=0, state=IDLE, sample count/sum/silent count = 0.
- FSM states: IDLE, ACCUM, SCORE, EMIT.
- IDLE -> ACCUM when enable=1. On that transition, target_bin is latched and count/sum/silent count are cleared.
- ACCUM, each peak_valid cycle:
  - err = |peak_bin - target_latched|, saturated to MAX_ERR=255 (8 bits).
  - sum += err; sum width is 8+LOG2_FRAME, so it cannot overflow.
  - count++.
  - When the accepted report makes count = 2^LOG2_FRAME, go to SCORE next cycle.
- SCORE (1 cycle):
  - avg = sum >> LOG2_FRAME.
  - dev = (avg > TOL) ? avg - TOL : 0.
  - steps = dev >> STEP_SHIFT.
  - Registered result: score_next = (steps >= 15) ? 0 : 15 - steps.
- EMIT (1 cycle):
  - score <= score_next and score_ready=1 (or silent=1 instead; see optional feature).
  - Then return to ACCUM with a fresh frame (target re-latched) if enable=1, else IDLE.
- Latency: score_ready is high exactly 2 cycles after the clock edge accepting the last report of the frame.
- peak_valid during SCORE or EMIT is discarded, never carried into the next frame.
- enable=0 in any state: next state IDLE, accumulators cleared, no pulse. This takes priority over the last report arriving the same cycle.
- target_bin changes mid-frame are ignored until the next frame start.
- Async reset mid-frame: all outputs return to reset values immediately; no partial score is emitted.
- score_ready and silent are never high together; each is high for at most one cycle per frame.

Optional Feature:
- Macro: PITCH_SCORER_SILENCE_GATE_EN.
- Defined:
  - A report with peak_mag < MAG_THRESH is silent: it adds MAX_ERR to sum, counts toward the frame and increments the silent count.
  - In EMIT, if silent count > 2^(LOG2_FRAME-1), pulse silent instead of score_ready and hold score unchanged.
- Undefined:
  - peak_mag is ignored, silent is tied 0 and no silent-count logic is built.

Decomposition:
- Package audio_score_pkg holds:
  - SCORE_W=4, SCORE_MAX=15, MAX_ERR=255.
  - The 2-bit state encoding (IDLE=0, ACCUM=1, SCORE=2, EMIT=3).
  - Shared by tally and future score consumers.
- One sub-module: score_map, combinational avg -> 4-bit score using TOL/STEP_SHIFT, reused by later scoring stages.

Test Plan:
- target_bin=100, enable=1, 8 reports peak_bin=100 -> score=15, score_ready high exactly 2 cycles after the 8th report.
- 8 reports peak_bin=106 (err 6) -> avg 6, dev 4, steps 2, score=13, one pulse.
- 8 reports peak_bin=400 (err 300, clamped 255) -> score=0. The next frame with peak_bin=100 -> score=15.
- enable dropped after 4 reports, then re-raised, 8 reports at bin 103 (err 3) -> no pulse for the aborted frame; the next frame gives score=15 (dev 1, steps 0).
- With PITCH_SCORER_SILENCE_GATE_EN, 5 of 8 reports with peak_mag=100 -> silent pulses once, score_ready stays 0, score keeps its previous value. Without the macro, the same stimulus at bin 100 -> score=15.
- reset asserted low after 5 reports, released, 8 on-pitch reports -> outputs 0 during reset, then a single score=15 pulse for the new frame only.
